// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NumReq requesters, with message lock.
// Define UART_ARB_TIMEOUT_EN to break a lock held by a stalled requester.
module uart_tx_arbiter #(
    parameter int NumReq        = 4,
    parameter int DataWidth     = 8,
    parameter int TimeoutCycles = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq-1:0]           req_last_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        tx_dv_o,
    output logic [DataWidth-1:0]        tx_data_o,
    input  logic                        tx_busy_i,
    output logic [$clog2(NumReq)-1:0]   grant_o,
    output logic                        lock_o,
    output logic                        timeout_o
);

    localparam int IdxW = $clog2(NumReq);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      rr_q, rr_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic                 lock_q, lock_d;
    logic [DataWidth-1:0] data_q, data_d;

    logic [NumReq-1:0]    eligible;
    logic [IdxW-1:0]      winner;
    logic                 found;
    logic                 timeout;

    function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] idx);
        return (int'(idx) == NumReq - 1) ? '0 : idx + IdxW'(1);
    endfunction

    // While locked only the owner may compete
    assign eligible = lock_q ? (req_valid_i & (NumReq'(1) << grant_q))
                             : req_valid_i;

    always_comb begin
        logic [IdxW-1:0] idx;
        found  = 1'b0;
        winner = rr_q;
        idx    = rr_q;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = inc_idx(idx);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stall;

    assign stall = (state_q == IDLE) && lock_q && !req_valid_i[grant_q];

    // Leaving IDLE always follows an accept, so clearing there covers it
    always_comb begin
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (!lock_q || state_q != IDLE) begin
            cnt_d = '0;
        end else if (stall) begin
            if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                timeout = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        lock_d      = lock_q;
        data_d      = data_q;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (!rst_i && !tx_busy_i && found) begin
                    req_ready_o[winner] = 1'b1;
                    data_d  = req_data_i[int'(winner)*DataWidth +: DataWidth];
                    grant_d = winner;
                    state_d = ISSUE;
                    if (req_last_i[winner]) begin
                        lock_d = 1'b0;
                        rr_d   = inc_idx(winner);
                    end else begin
                        lock_d = 1'b1;
                    end
                end else if (timeout) begin
                    lock_d = 1'b0;
                    rr_d   = inc_idx(grant_q);
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!tx_busy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
        end
    end

    assign tx_dv_o   = (state_q == ISSUE);
    assign tx_data_o = data_q;
    assign grant_o   = grant_q;
    assign lock_o    = lock_q;
    assign timeout_o = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a transaction-timeline reference model.
// Honours UART_ARB_TIMEOUT_EN the same way the design does.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic [N-1:0]  req_valid_i = '0;
    logic [N-1:0]  req_last_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]  req_ready_o;
    logic          tx_dv_o;
    logic [DW-1:0] tx_data_o;
    logic          tx_busy_i = 1'b0;
    logic [1:0]    grant_o;
    logic          lock_o;
    logic          timeout_o;

    uart_tx_arbiter #(
        .NumReq(N),
        .DataWidth(DW),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_last_i(req_last_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .tx_dv_o(tx_dv_o),
        .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i),
        .grant_o(grant_o),
        .lock_o(lock_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // requester message queues: {last, byte}
    logic [8:0] rq[N][$];
    logic [N-1:0] en = '1;
    int stall_left[N];
    logic [7:0] dv_log[$];
    int n_to = 0;
    int busy_left = 0;
    bit glitch_en = 0;

    // reference model: timeline of accepts
    int   cyc = 0;
    bit   m_has_acc = 0;
    int   m_acc_cyc = 0;
    bit   m_freed = 0;
    bit   m_lock = 0;
    int   m_grant = 0;
    int   m_rr = 0;
    logic [7:0] m_data = '0;
    int   m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            if (!rst_i && en[r] && rq[r].size() > 0) begin
                req_valid_i[r]          = 1'b1;
                req_last_i[r]           = rq[r][0][8];
                req_data_i[r*DW +: DW]  = rq[r][0][7:0];
            end else begin
                req_valid_i[r]          = 1'b0;
                req_last_i[r]           = 1'($urandom_range(0, 1));
                req_data_i[r*DW +: DW]  = 8'($urandom);
            end
        end
    endtask

    task automatic step();
        bit can_acc, acc, exp_dv, exp_to, stall, dv_seen, rst_was;
        logic [N-1:0] elig, exp_rdy;
        int w;
        drive_inputs();
        #1;
        rst_was = rst_i;
        dv_seen = tx_dv_o;
        if (!rst_i) begin
            can_acc = !m_has_acc || m_freed;
            elig = m_lock ? (req_valid_i & (4'b0001 << m_grant)) : req_valid_i;
            w = -1;
            for (int k = 0; k < N; k++) begin
                int r;
                r = (m_rr + k) % N;
                if (w < 0 && elig[r]) w = r;
            end
            acc     = can_acc && !tx_busy_i && (w >= 0);
            exp_rdy = acc ? 4'(1 << w) : 4'b0000;
            exp_dv  = m_has_acc && (cyc == m_acc_cyc + 1);
            stall   = can_acc && m_lock && !req_valid_i[m_grant];
            exp_to  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            exp_to  = stall && (m_cnt == TO - 1);
`endif
            chk("ready", 32'(req_ready_o), 32'(exp_rdy));
            chk("tx_dv", 32'(tx_dv_o), 32'(exp_dv));
            chk("tx_data", 32'(tx_data_o), 32'(m_data));
            chk("grant", 32'(grant_o), m_grant);
            chk("lock", 32'(lock_o), 32'(m_lock));
            chk("timeout", 32'(timeout_o), 32'(exp_to));

            if (m_has_acc && cyc >= m_acc_cyc + 2 && !tx_busy_i) m_freed = 1;
            if (!m_lock || !can_acc) m_cnt = 0;
            else if (stall) m_cnt = exp_to ? 0 : m_cnt + 1;
            if (acc) begin
                m_has_acc = 1;
                m_acc_cyc = cyc;
                m_freed   = 0;
                m_data    = req_data_i[w*DW +: DW];
                m_grant   = w;
                if (req_last_i[w]) begin
                    m_lock = 0;
                    m_rr   = (w + 1) % N;
                end else begin
                    m_lock = 1;
                end
            end else if (exp_to) begin
                m_lock = 0;
                m_rr   = (m_grant + 1) % N;
            end

            for (int r = 0; r < N; r++)
                if (req_valid_i[r] && req_ready_o[r]) void'(rq[r].pop_front());
            if (tx_dv_o) dv_log.push_back(tx_data_o);
            if (timeout_o) n_to++;
        end else begin
            m_has_acc = 0;
            m_freed   = 0;
            m_lock    = 0;
            m_grant   = 0;
            m_rr      = 0;
            m_data    = '0;
            m_cnt     = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (rst_was) busy_left = 0;
        else if (dv_seen) busy_left = $urandom_range(2, 8);
        else if (busy_left > 0) busy_left--;
        else if (glitch_en && $urandom_range(0, 19) == 0)
            busy_left = $urandom_range(1, 3);
        tx_busy_i = (busy_left != 0);
    endtask

    task automatic do_reset();
        for (int r = 0; r < N; r++) rq[r].delete();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        dv_log.delete();
        n_to = 0;
    endtask

    task automatic run_until(input int n, input int budget);
        int b;
        b = 0;
        while (dv_log.size() < n && b < budget) begin
            step();
            b++;
        end
    endtask

    task automatic chk_log(input string name, input logic [39:0] exp,
                           input int n);
        chk({name, "_count"}, 32'(dv_log.size()), n);
        for (int i = 0; i < n; i++)
            if (i < dv_log.size())
                chk(name, 32'(dv_log[i]), 32'(exp[(n-1-i)*8 +: 8]));
    endtask

    initial begin
        for (int r = 0; r < N; r++) stall_left[r] = 0;

        // single byte from r0
        do_reset();
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_dv", 32'(tx_dv_o), 0);
        chk("rst_data", 32'(tx_data_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_lock", 32'(lock_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        rq[0].push_back({1'b1, 8'h55});
        drive_inputs();
        #1;
        chk("t1_ready", 32'(req_ready_o), 32'h1);
        step();
        chk("t1_dv", 32'(tx_dv_o), 1);
        chk("t1_data", 32'(tx_data_o), 32'h55);
        chk("t1_lock", 32'(lock_o), 0);
        chk("t1_grant", 32'(grant_o), 0);
        repeat (12) step();

        // rotation with all requesters valid
        do_reset();
        for (int r = 0; r < N; r++)
            repeat (4) rq[r].push_back({1'b1, 8'(8'hA0 + r)});
        run_until(5, 200);
        chk_log("t2_order", 40'hA0A1A2A3A0, 5);

        // locked three-byte message from r1
        do_reset();
        rq[1].push_back({1'b0, 8'h10});
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b1, 8'h12});
        step();
        chk("t3_lock_set", 32'(lock_o), 1);
        rq[0].push_back({1'b1, 8'h30});
        rq[2].push_back({1'b1, 8'h20});
        run_until(5, 200);
        chk_log("t3_order", 40'h1011122030, 5);
        repeat (12) step();
        chk("t3_lock_clr", 32'(lock_o), 0);

        // lock held by a stalled r2
        do_reset();
        rq[2].push_back({1'b0, 8'h40});
        run_until(1, 20);
        en[2] = 1'b0;
        rq[3].push_back({1'b1, 8'h50});
        repeat (60) step();
`ifdef UART_ARB_TIMEOUT_EN
        chk_log("t4_order", 40'h4050, 2);
        chk("t4_timeouts", 32'(n_to), 1);
        chk("t4_lock", 32'(lock_o), 0);
`else
        chk_log("t4_order", 40'h40, 1);
        chk("t4_timeouts", 32'(n_to), 0);
        chk("t4_lock", 32'(lock_o), 1);
`endif
        en[2] = 1'b1;

        // reset during WAIT while locked
        do_reset();
        rq[1].push_back({1'b0, 8'h60});
        rq[1].push_back({1'b1, 8'h61});
        run_until(1, 20);
        step();
        chk("t5_lock_pre", 32'(lock_o), 1);
        do_reset();
        chk("t5_ready", 32'(req_ready_o), 0);
        chk("t5_dv", 32'(tx_dv_o), 0);
        chk("t5_data", 32'(tx_data_o), 0);
        chk("t5_grant", 32'(grant_o), 0);
        chk("t5_lock", 32'(lock_o), 0);
        rq[3].push_back({1'b1, 8'h70});
        rq[0].push_back({1'b1, 8'h71});
        run_until(1, 20);
        chk_log("t5_first", 40'h71, 1);

        // randomized traffic
        glitch_en = 1;
        repeat (3000) begin
            for (int r = 0; r < N; r++) begin
                if (rq[r].size() == 0 && $urandom_range(0, 9) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++)
                        rq[r].push_back({1'(i == len - 1), 8'($urandom)});
                end
                if (stall_left[r] > 0) begin
                    stall_left[r]--;
                    en[r] = 1'b0;
                end else if ($urandom_range(0, 99) < 2) begin
                    stall_left[r] = $urandom_range(10, 30);
                    en[r] = 1'b0;
                end else begin
                    en[r] = ($urandom_range(0, 9) < 7);
                end
            end
            rst_i = ($urandom_range(0, 499) == 0);
            step();
            rst_i = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
